sr_mem_arbiter: RTL and testbench

SR_MEM_ARBITER -- requirements
Module: sr_mem_arbiter

---
 rtl/sr_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_sr_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_mem_arbiter.sv
// sr_mem_arbiter: merges a fetch port and a data port onto one memory port.
// At most one read may be outstanding. Data requests normally win, but a
// starvation counter hands the port to a waiting fetch after STARVE_MAX
// consecutive data grants.
module sr_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-3:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_ready,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata,
  // status
  output logic              err_rvalid
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             err_rvalid_q, err_rvalid_d;

  logic i_wins;
  logic d_wins;
  logic can_issue;
  logic xfer;
  logic rsp_valid;
  logic read_gnt;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  // Arbitration, memory request muxing, grants and read-data steering.
  always_comb begin
    i_wins    = i_req && (!d_req || (starve_q == STARVE_LIM));
    d_wins    = d_req && !i_wins;
    can_issue = (state_q == IDLE) || m_rvalid;
    m_req     = !rst && can_issue && (i_req || d_req);
    m_we      = 1'b0;
    m_be      = 4'b1111;
    m_addr    = i_addr[ADDR_W-1:2];
    m_wdata   = '0;
    if (d_wins) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr[ADDR_W-1:2];
      m_wdata = d_wdata;
    end
    xfer      = m_req && m_ready;
    i_gnt     = xfer && i_wins;
    d_gnt     = xfer && d_wins;
    rsp_valid = !rst && (state_q == WAIT) && m_rvalid;
    i_rvalid  = rsp_valid && !owner_q;
    d_rvalid  = rsp_valid && owner_q;
    i_rdata   = i_rvalid ? m_rdata : '0;
    d_rdata   = d_rvalid ? m_rdata : '0;
  end

  // Next state, read owner, starvation counter and sticky error flag.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_d     = starve_q;
    err_rvalid_d = err_rvalid_q;
    read_gnt     = i_gnt || (d_gnt && !d_we);

    if (read_gnt) begin
      state_d = WAIT;
      owner_d = d_gnt;
    end else if ((state_q == WAIT) && m_rvalid) begin
      state_d = IDLE;
    end

    if ((state_q == IDLE) && m_rvalid) begin
      err_rvalid_d = 1'b1;
    end

    if (!i_req || i_gnt) begin
      starve_d = '0;
    end else if (d_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // State registers; reset abandons any outstanding read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_q     <= '0;
      err_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_q     <= starve_d;
      err_rvalid_q <= err_rvalid_d;
    end
  end

  assign err_rvalid = err_rvalid_q;

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// tb_sr_mem_arbiter: directed bench for sr_mem_arbiter with a small
// latency-programmable memory model and a read-response scoreboard.
module tb_sr_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 2;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              m_req;
  logic              m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-3:0] m_addr;
  logic [31:0]       m_wdata;
  logic              m_ready;
  logic              m_rvalid;
  logic [31:0]       m_rdata;
  logic              err_rvalid;

  sr_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_be      (m_be),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .err_rvalid(err_rvalid)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        to_data;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  int          vectors     = 0;
  int          miscompares = 0;

  int          mem_lat     = 1;
  bit          mem_pending = 1'b0;
  int          mem_count   = 0;
  logic [29:0] mem_addr_q  = '0;
  bit          xfer_seen   = 1'b0;
  logic [29:0] xfer_addr   = '0;
  bit          resp_now    = 1'b0;
  bit          spurious    = 1'b0;

  // Memory contents: one fixed instruction word, everything else address-derived.
  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (wa == 30'h4) return 32'h0050_0513;
    return {2'b01, wa} ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expectRead(input logic to_data, input logic [31:0] byte_addr);
    resp_t r;
    r.to_data = to_data;
    r.data    = mem_word(byte_addr[31:2]);
    sb.push_back(r);
  endtask

  // Compares the response ports against the scoreboard every cycle.
  task automatic checkResponse();
    resp_t exp_r;
    if (resp_now) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("[TB] FAIL sb_underflow: observed read return, expected none queued");
      end else begin
        exp_r = sb.pop_front();
        checkOutput("i_rvalid", 32'(i_rvalid), 32'(!exp_r.to_data));
        checkOutput("d_rvalid", 32'(d_rvalid), 32'(exp_r.to_data));
        checkOutput("i_rdata", i_rdata, exp_r.to_data ? 32'h0 : exp_r.data);
        checkOutput("d_rdata", d_rdata, exp_r.to_data ? exp_r.data : 32'h0);
      end
    end else begin
      checkOutput("i_rvalid_quiet", 32'(i_rvalid), 32'h0);
      checkOutput("d_rvalid_quiet", 32'(d_rvalid), 32'h0);
      checkOutput("i_rdata_quiet", i_rdata, 32'h0);
      checkOutput("d_rdata_quiet", d_rdata, 32'h0);
    end
  endtask

  // Drives one cycle of requester and memory inputs at the falling edge,
  // then lets combinational outputs settle before anything is compared.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe,
                               input logic [3:0] dbe, input logic [31:0] daddr,
                               input logic [31:0] dwdata, input logic mready);
    @(negedge clk);
    i_req   = ireq;
    i_addr  = iaddr;
    d_req   = dreq;
    d_we    = dwe;
    d_be    = dbe;
    d_addr  = daddr;
    d_wdata = dwdata;
    m_ready = mready;
    if (xfer_seen) begin
      mem_pending = 1'b1;
      mem_count   = mem_lat - 1;
      mem_addr_q  = xfer_addr;
      xfer_seen   = 1'b0;
    end
    resp_now = 1'b0;
    if (spurious) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hCAFE_F00D;
    end else if (mem_pending && (mem_count == 0)) begin
      resp_now    = 1'b1;
      mem_pending = 1'b0;
      m_rvalid    = 1'b1;
      m_rdata     = mem_word(mem_addr_q);
    end else begin
      if (mem_pending) mem_count--;
      m_rvalid = 1'b0;
      m_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (m_req && m_ready && !m_we) begin
      xfer_seen = 1'b1;
      xfer_addr = m_addr;
    end
    checkResponse();
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
  endtask

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    rst      = 1'b1;
    i_req    = 1'b0;
    i_addr   = '0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_be     = 4'h0;
    d_addr   = '0;
    d_wdata  = '0;
    m_ready  = 1'b0;
    m_rvalid = 1'b0;
    m_rdata  = '0;

    // Reset holds everything quiet even with requests present.
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1);
    checkOutput("rst_m_req", 32'(m_req), 32'h0);
    checkOutput("rst_i_gnt", 32'(i_gnt), 32'h0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'h0);
    checkOutput("rst_err", 32'(err_rvalid), 32'h0);
    idleStep();
    rst = 1'b0;

    // Single fetch, 1-cycle memory, granted on the first edge after reset.
    $display("[TB] fetch only");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("f_i_gnt", 32'(i_gnt), 32'h1);
    checkOutput("f_d_gnt", 32'(d_gnt), 32'h0);
    checkOutput("f_m_req", 32'(m_req), 32'h1);
    checkOutput("f_m_addr", 32'(m_addr), 32'h4);
    checkOutput("f_m_we", 32'(m_we), 32'h0);
    checkOutput("f_m_be", 32'(m_be), 32'hF);
    expectRead(1'b0, 32'h10);
    idleStep();
    checkOutput("f_i_rdata_val", i_rdata, 32'h0050_0513);

    // Contending fetch and load: d,d,i,d,d,i.
    $display("[TB] starvation order");
    for (int k = 0; k < 6; k++) begin
      logic exp_d;
      exp_d = ((k % 3) != 2);
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 1'b1);
      checkOutput($sformatf("arb%0d_d_gnt", k), 32'(d_gnt), 32'(exp_d));
      checkOutput($sformatf("arb%0d_i_gnt", k), 32'(i_gnt), 32'(!exp_d));
      checkOutput($sformatf("arb%0d_m_addr", k), 32'(m_addr), exp_d ? 32'h40 : 32'h10);
      expectRead(exp_d, exp_d ? 32'h100 : 32'h40);
    end
    idleStep();

    // Store: no read outstanding afterwards.
    $display("[TB] store");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h203, 32'h0000_AB00, 1'b1);
    checkOutput("st_d_gnt", 32'(d_gnt), 32'h1);
    checkOutput("st_m_addr", 32'(m_addr), 32'h80);
    checkOutput("st_m_be", 32'(m_be), 32'h2);
    checkOutput("st_m_we", 32'(m_we), 32'h1);
    checkOutput("st_m_wdata", m_wdata, 32'h0000_AB00);

    // Memory not ready for three cycles; request must persist (still IDLE).
    $display("[TB] backpressure");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h2C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
      checkOutput($sformatf("bp%0d_m_req", k), 32'(m_req), 32'h1);
      checkOutput($sformatf("bp%0d_i_gnt", k), 32'(i_gnt), 32'h0);
      checkOutput($sformatf("bp%0d_m_addr", k), 32'(m_addr), 32'hB);
    end
    applyStimulus(1'b1, 32'h2C, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("bp3_i_gnt", 32'(i_gnt), 32'h1);
    checkOutput("bp3_m_addr", 32'(m_addr), 32'hB);
    expectRead(1'b0, 32'h2C);
    idleStep();
    checkOutput("bp_err", 32'(err_rvalid), 32'h0);

    // 3-cycle memory, back-to-back fetches.
    $display("[TB] slow memory");
    mem_lat = 3;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("sl_a_gnt", 32'(i_gnt), 32'h1);
    expectRead(1'b0, 32'h80);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      checkOutput($sformatf("sl_wait%0d_m_req", k), 32'(m_req), 32'h0);
      checkOutput($sformatf("sl_wait%0d_gnt", k), 32'(i_gnt), 32'h0);
    end
    applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("sl_b_m_req", 32'(m_req), 32'h1);
    checkOutput("sl_b_gnt", 32'(i_gnt), 32'h1);
    checkOutput("sl_b_m_addr", 32'(m_addr), 32'h21);
    expectRead(1'b0, 32'h84);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 32'h88, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
      checkOutput($sformatf("sl_wait_b%0d_m_req", k), 32'(m_req), 32'h0);
    end
    applyStimulus(1'b1, 32'h88, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("sl_c_gnt", 32'(i_gnt), 32'h1);
    expectRead(1'b0, 32'h88);
    for (int k = 0; k < 3; k++) idleStep();
    checkOutput("sl_sb_drained", 32'(sb.size()), 32'h0);

    // Reset while a read is outstanding, then a stray memory response.
    $display("[TB] reset mid-read");
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("rw_gnt", 32'(i_gnt), 32'h1);
    idleStep();
    rst = 1'b1;
    #1;
    mem_pending = 1'b0;
    xfer_seen   = 1'b0;
    sb.delete();
    idleStep();
    checkOutput("rw_err_in_rst", 32'(err_rvalid), 32'h0);
    rst = 1'b0;
    spurious = 1'b1;
    idleStep();
    spurious = 1'b0;
    idleStep();
    checkOutput("rw_err_set", 32'(err_rvalid), 32'h1);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    checkOutput("rw_regrant", 32'(i_gnt), 32'h1);
    checkOutput("rw_err_sticky", 32'(err_rvalid), 32'h1);
    expectRead(1'b0, 32'h10);
    for (int k = 0; k < 3; k++) idleStep();
    checkOutput("rw_sb_drained", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
